// File: rtl/pipe_pkg.sv
// Shared constants for the skid-buffered pipeline register: state encoding and default width.
// Pure definitions, no logic.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/register_n.sv
// N-bit storage register with enable and optional zeroing on reset or clear.
// 1-cycle load latency; priority is reset, then clear, then enable.
module register_n #(
  parameter int WIDTH = pipe_pkg::DEFAULT_WIDTH,
  parameter bit CLEAR = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // With CLEAR=0, reset and clear still block a load but leave the contents alone.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      if (CLEAR) data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_reg_skid.sv
// Full-throughput pipeline register with one-entry skid buffer, flush and registered in_ready.
// 1-cycle latency; when the skid is occupied in_ready drops until downstream pops.
module pipe_reg_skid
  import pipe_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic [1:0]       occ
);

  pipe_state_t      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             accept, pop;
  logic             load_main, load_skid, main_from_skid;
  logic [WIDTH-1:0] main_q, skid_q, main_d;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d   = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d        = ST_ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A pop still completes downstream during flush; only the stored words are discarded.
    if (flush) begin
      state_d   = ST_EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign main_d = main_from_skid ? skid_q : in1;

  register_n #(.WIDTH(WIDTH), .CLEAR(CLEAR_DATA)) u_main (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (flush),
    .en_i  (load_main),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  register_n #(.WIDTH(WIDTH), .CLEAR(CLEAR_DATA)) u_skid (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (flush),
    .en_i  (load_skid),
    .d_i   (in1),
    .q_o   (skid_q)
  );

  always_comb begin
    case (state_q)
      ST_ONE:  occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out1      = main_q;

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: two instances (CLEAR_DATA=1 and 0) checked against a queue model.
// Directed scenarios first, then a randomized phase.
module tb_pipe_reg_skid;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [W-1:0] in1;
  logic         in_ready1, out_valid1, in_ready0, out_valid0;
  logic [W-1:0] out1_c1, out1_c0;
  logic [1:0]   occ1, occ0;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] main1, main0;
  bit           main0_known;

  always #5 clk = ~clk;

  pipe_reg_skid #(.WIDTH(W), .CLEAR_DATA(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in1(in1), .out_valid(out_valid1), .out_ready(out_ready), .out1(out1_c1), .occ(occ1)
  );

  pipe_reg_skid #(.WIDTH(W), .CLEAR_DATA(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in1(in1), .out_valid(out_valid0), .out_ready(out_ready), .out1(out1_c0), .occ(occ0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] ov;
    logic         exp_ov, exp_ir;
    logic [1:0]   exp_occ;
    exp_ov  = (mq.size() > 0);
    exp_ir  = (mq.size() < 2);
    exp_occ = 2'(mq.size());
    chk("c1.out_valid", 32'(out_valid1), 32'(exp_ov));
    chk("c1.in_ready",  32'(in_ready1),  32'(exp_ir));
    chk("c1.occ",       32'(occ1),       32'(exp_occ));
    ov = (mq.size() > 0) ? mq[0] : main1;
    chk("c1.out1",      32'(out1_c1),    32'(ov));
    chk("c0.out_valid", 32'(out_valid0), 32'(exp_ov));
    chk("c0.in_ready",  32'(in_ready0),  32'(exp_ir));
    chk("c0.occ",       32'(occ0),       32'(exp_occ));
    if (main0_known) begin
      ov = (mq.size() > 0) ? mq[0] : main0;
      chk("c0.out1", 32'(out1_c0), 32'(ov));
    end
  endtask

  // Sample the handshake from the model's view, clock once, update the model, check outputs.
  task automatic tick();
    bit acc, pp;
    acc = in_valid && (mq.size() < 2);
    pp  = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
      main1 = '0;
    end else begin
      if (pp)  void'(mq.pop_front());
      if (acc) mq.push_back(in1);
      if (mq.size() > 0) begin
        main1       = mq[0];
        main0       = mq[0];
        main0_known = 1'b1;
      end
    end
    #1;
    check_all();
  endtask

  task automatic drive(input bit r, input bit f, input bit v, input logic [W-1:0] d, input bit ordy);
    rst       = r;
    flush     = f;
    in_valid  = v;
    in1       = d;
    out_ready = ordy;
  endtask

  initial begin
    main1       = '0;
    main0       = '0;
    main0_known = 1'b0;

    // Reset held two cycles with a word offered, then one idle cycle.
    drive(1, 0, 1, 4'hF, 1);
    tick(); tick();
    drive(0, 0, 0, 4'h0, 1);
    tick();

    // Single transfer.
    drive(0, 0, 1, 4'hA, 1); tick();
    drive(0, 0, 0, 4'h0, 1); tick(); tick();

    // Streaming 1..5.
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 1, 4'(i), 1); tick();
    end
    drive(0, 0, 0, 4'h0, 1); tick(); tick();

    // Back-pressure: 3 and 7 fill the block, 9 waits, then drain in order.
    drive(0, 0, 1, 4'h3, 0); tick();
    drive(0, 0, 1, 4'h7, 0); tick();
    drive(0, 0, 1, 4'h9, 0); tick(); tick();
    drive(0, 0, 1, 4'h9, 1); tick(); tick();
    drive(0, 0, 0, 4'h0, 1); tick(); tick();

    // Flush while FULL with a word offered.
    drive(0, 0, 1, 4'h3, 0); tick();
    drive(0, 0, 1, 4'h7, 0); tick();
    drive(0, 1, 1, 4'hC, 0); tick();
    drive(0, 0, 0, 4'h0, 0); tick(); tick();

    // Flush in ONE with an accept and a pop in the same cycle.
    drive(0, 0, 1, 4'h5, 0); tick();
    drive(0, 1, 1, 4'h6, 1); tick();
    drive(0, 0, 0, 4'h0, 1); tick();

    // Reset beats flush and accept; CLEAR_DATA=0 instance keeps its last word.
    drive(0, 0, 1, 4'h8, 0); tick();
    drive(1, 1, 1, 4'h2, 1); tick();
    drive(0, 0, 0, 4'h0, 0); tick(); tick();

    // Randomized traffic, honouring the hold-while-stalled obligation upstream.
    for (int n = 0; n < 500; n++) begin
      bit r, f, v, o;
      logic [W-1:0] d;
      r = ($urandom_range(0, 59) == 0);
      f = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 2) != 0);
      d = W'($urandom);
      if (in_valid && mq.size() == 2 && !rst && !flush) begin
        v = 1'b1;
        d = in1;
      end
      drive(r, f, v, d, o);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
